// File: rtl/mem_load_unit_pkg.sv
// mem_load_unit_pkg: load-size and load-FSM encodings shared by the MEM and WB stages.
package mem_load_unit_pkg;
  typedef enum logic [1:0] {LD_B = 2'd0, LD_H = 2'd1, LD_W = 2'd2, LD_D = 2'd3} ld_size_e;
  typedef logic [2:0] ld_state_e;
  localparam ld_state_e ST_IDLE  = 3'd0;
  localparam ld_state_e ST_REQ   = 3'd1;
  localparam ld_state_e ST_WAIT  = 3'd2;
  localparam ld_state_e ST_DRAIN = 3'd3;
  localparam ld_state_e ST_DONE  = 3'd4;
endpackage

// File: rtl/mem_load_unit_ld_extract.sv
// ld_extract: selects the addressed lane of a 64-bit read and sign/zero-extends it.
module ld_extract
  import mem_load_unit_pkg::*;
(
  input  logic     [63:0] i_rdata,
  input  logic     [2:0]  i_off,
  input  ld_size_e        i_size,
  input  logic            i_unsigned,
  output logic     [63:0] o_data
);
  logic [2:0]  w_lane;
  logic [63:0] w_sh;
  // Low offset bits below the access size are dropped: lanes are always naturally aligned.
  assign w_lane = (i_size == LD_B) ? i_off :
                  (i_size == LD_H) ? {i_off[2:1], 1'b0} :
                  (i_size == LD_W) ? {i_off[2], 2'b00} : 3'b000;
  assign w_sh = i_rdata >> {w_lane, 3'b000};
  always_comb begin
    o_data = (i_size == LD_B) ? {{56{~i_unsigned & w_sh[7]}}, w_sh[7:0]} :
             (i_size == LD_H) ? {{48{~i_unsigned & w_sh[15]}}, w_sh[15:0]} :
             (i_size == LD_W) ? {{32{~i_unsigned & w_sh[31]}}, w_sh[31:0]} : w_sh;
  end
endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: MEM-stage load FSM issuing aligned 64-bit reads, with watchdog.
// Optional MEM_LOAD_MISALIGN_TRAP_EN turns misaligned H/W/D loads into a trap.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int MAX_WAIT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_addr,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic [XLEN-1:0] o_rd_data,
  output logic            o_done,
  output logic            o_staller,
  output logic            o_misaligned,
  output logic            o_timeout
);
  localparam int CW = $clog2(MAX_WAIT + 2);
  ld_state_e       r_state;
  logic [XLEN-1:0] r_addr, r_data;
  ld_size_e        r_size;
  logic            r_uns, r_mis;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] w_res;
  logic            w_mis, w_to, w_acc;

  ld_extract u_ext (
    .i_rdata   (i_mem_rdata),
    .i_off     (r_addr[2:0]),
    .i_size    (r_size),
    .i_unsigned(r_uns),
    .o_data    (w_res)
  );

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
  assign w_mis = (i_size == LD_H && i_addr[0]) || (i_size == LD_W && i_addr[1:0] != 2'b00) ||
                 (i_size == LD_D && i_addr[2:0] != 3'b000);
`else
  assign w_mis = 1'b0;
`endif

  assign w_acc = r_state == ST_IDLE && i_valid && !i_flush;
  // Data arrival or a flush in the expiring cycle takes precedence over the watchdog.
  assign w_to = MAX_WAIT != 0 && r_cnt == CW'(MAX_WAIT) &&
                ((r_state == ST_WAIT && !i_mem_rvalid && !i_flush) || (r_state == ST_DRAIN && !i_mem_rvalid));

  assign o_mem_req    = r_state == ST_REQ;
  assign o_mem_addr   = {r_addr[XLEN-1:3], 3'b000};
  assign o_rd_data    = r_data;
  assign o_done       = r_state == ST_DONE;
  assign o_misaligned = r_mis;
  assign o_timeout    = w_to;
  assign o_staller    = w_acc || r_state == ST_REQ || r_state == ST_WAIT || r_state == ST_DRAIN;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= LD_B;
      r_uns   <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= (MAX_WAIT != 0 && (r_state == ST_WAIT || r_state == ST_DRAIN)) ? r_cnt + 1'b1 : '0;
      case (r_state)
        ST_IDLE: if (w_acc) begin
          r_addr  <= i_addr;
          r_size  <= ld_size_e'(i_size);
          r_uns   <= i_unsigned;
          r_mis   <= w_mis;
          if (w_mis) r_data <= '0;
          r_state <= w_mis ? ST_DONE : ST_REQ;
        end
        ST_REQ: if (i_mem_gnt) r_state <= i_flush ? ST_DRAIN : ST_WAIT;
                else if (i_flush) r_state <= ST_IDLE;
        ST_WAIT: if (i_mem_rvalid) begin
          if (!i_flush) r_data <= w_res;
          r_state <= i_flush ? ST_IDLE : ST_DONE;
        end else if (i_flush) r_state <= ST_DRAIN;
        else if (w_to) r_state <= ST_IDLE;
        ST_DRAIN: if (i_mem_rvalid || w_to) r_state <= ST_IDLE;
        ST_DONE: if (!i_stall || i_flush) begin
          r_state <= ST_IDLE;
          r_mis   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed checks of mem_load_unit (MAX_WAIT=8), honours MEM_LOAD_MISALIGN_TRAP_EN.
module tb_mem_load_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        i_valid = 0, i_unsigned = 0, i_stall = 0, i_flush = 0, i_mem_gnt = 0, i_mem_rvalid = 0;
  logic [63:0] i_addr = '0, i_mem_rdata = '0;
  logic [1:0]  i_size = '0;
  logic        o_mem_req, o_done, o_staller, o_misaligned, o_timeout;
  logic [63:0] o_mem_addr, o_rd_data;
  int          n_chk = 0, n_err = 0, wd;

  mem_load_unit #(.XLEN(64), .MAX_WAIT(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_addr(i_addr), .i_size(i_size),
    .i_unsigned(i_unsigned), .i_stall(i_stall), .i_flush(i_flush), .o_mem_req(o_mem_req),
    .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid),
    .i_mem_rdata(i_mem_rdata), .o_rd_data(o_rd_data), .o_done(o_done), .o_staller(o_staller),
    .o_misaligned(o_misaligned), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input logic [63:0] a, input logic [1:0] sz, input logic u,
                         input logic [63:0] rd, input logic [63:0] exp);
    cyc(); i_valid = 1; i_addr = a; i_size = sz; i_unsigned = u;
    #1 chk({tag, ".acc_stall"}, 64'(o_staller), 1);
    cyc(); i_valid = 0; i_addr = ~a; i_mem_gnt = 1;
    #1 chk({tag, ".req"}, 64'(o_mem_req), 1);
    chk({tag, ".addr"}, o_mem_addr, {a[63:3], 3'b000});
    cyc(); i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = rd;
    #1 chk({tag, ".wait_done"}, 64'(o_done), 0);
    cyc(); i_mem_rvalid = 0;
    #1 chk({tag, ".done"}, 64'(o_done), 1);
    chk({tag, ".data"}, o_rd_data, exp);
    chk({tag, ".done_stall"}, 64'(o_staller), 0);
    cyc();
    #1 chk({tag, ".idle"}, 64'(o_done), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    #1 chk("rst.req", 64'(o_mem_req), 0);
    chk("rst.done", 64'(o_done), 0);
    chk("rst.data", o_rd_data, 0);
    chk("rst.addr", o_mem_addr, 0);
    cyc(); cyc(); rst = 0;
    #1 chk("rst.staller", 64'(o_staller), 0);

    do_load("lb", 64'h1003, 2'd0, 0, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lwu", 64'h2004, 2'd2, 1, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    do_load("lw", 64'h2004, 2'd2, 0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    do_load("lbu", 64'h1006, 2'd0, 1, 64'h00C3_0000_0000_0000, 64'h0000_0000_0000_00C3);
    do_load("ld", 64'h5008, 2'd3, 1, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);

    // gnt withheld, late rvalid, stalled DONE
    cyc(); i_valid = 1; i_addr = 64'h6002; i_size = 2'd1; i_unsigned = 1;
    cyc(); i_valid = 0; i_addr = 64'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      #1 chk("hold.req", 64'(o_mem_req), 1);
      chk("hold.addr", o_mem_addr, 64'h6000);
      chk("hold.stall", 64'(o_staller), 1);
      cyc();
    end
    i_mem_gnt = 1;
    cyc(); i_mem_gnt = 0;
    cyc(); #1 chk("late.stall", 64'(o_staller), 1);
    cyc(); i_mem_rvalid = 1; i_mem_rdata = 64'h0000_0000_ABCD_1234;
    cyc(); i_mem_rvalid = 0; i_stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("stl.done", 64'(o_done), 1);
      chk("stl.data", o_rd_data, 64'h0000_0000_0000_ABCD);
      i_mem_rvalid = 1; i_mem_rdata = 64'h1111;
      cyc(); i_mem_rvalid = 0;
    end
    i_stall = 0;
    #1 chk("stl.last", 64'(o_done), 1);
    cyc(); #1 chk("stl.exit", 64'(o_done), 0);
    chk("stl.keep", o_rd_data, 64'h0000_0000_0000_ABCD);

    // flush in WAIT, DRAIN swallows the late rvalid
    cyc(); i_valid = 1; i_addr = 64'h4000; i_size = 2'd3;
    cyc(); i_valid = 0; i_mem_gnt = 1;
    cyc(); i_mem_gnt = 0; i_flush = 1;
    cyc(); i_flush = 0;
    #1 chk("drn.stall", 64'(o_staller), 1);
    cyc(); i_mem_rvalid = 1; i_mem_rdata = 64'h5555;
    #1 chk("drn.done", 64'(o_done), 0);
    cyc(); i_mem_rvalid = 0;
    #1 chk("drn.idle", 64'(o_staller), 0);
    chk("drn.nodone", 64'(o_done), 0);
    do_load("post", 64'h4001, 2'd0, 0, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F);

`ifdef MEM_LOAD_MISALIGN_TRAP_EN
    cyc(); i_valid = 1; i_addr = 64'h3001; i_size = 2'd1; i_unsigned = 0;
    cyc(); i_valid = 0;
    #1 chk("mis.req", 64'(o_mem_req), 0);
    chk("mis.flag", 64'(o_misaligned), 1);
    chk("mis.done", 64'(o_done), 1);
    chk("mis.data", o_rd_data, 0);
    cyc(); #1 chk("mis.clear", 64'(o_misaligned), 0);
`else
    do_load("lh_mis", 64'h3001, 2'd1, 0, 64'h0000_0000_0000_9ABC, 64'hFFFF_FFFF_FFFF_9ABC);
    chk("mis.tied", 64'(o_misaligned), 0);
`endif

    // async reset in WAIT, then stale rvalid
    cyc(); i_valid = 1; i_addr = 64'h7000; i_size = 2'd3;
    cyc(); i_valid = 0; i_mem_gnt = 1;
    cyc(); i_mem_gnt = 0; rst = 1;
    #1 chk("arst.stall", 64'(o_staller), 0);
    chk("arst.data", o_rd_data, 0);
    chk("arst.addr", o_mem_addr, 0);
    cyc(); i_mem_rvalid = 1; i_mem_rdata = 64'h9999;
    cyc(); rst = 0;
    cyc(); i_mem_rvalid = 0;
    #1 chk("arst.done", 64'(o_done), 0);
    chk("arst.data2", o_rd_data, 0);

    // watchdog: 8 WAIT cycles then a one-cycle pulse
    cyc(); i_valid = 1; i_addr = 64'h8000; i_size = 2'd3;
    cyc(); i_valid = 0; i_mem_gnt = 1;
    cyc(); i_mem_gnt = 0;
    wd = 20;
    for (int i = 0; i < 20; i++) begin
      #1 if (o_timeout) begin wd = i; break; end
      cyc();
    end
    chk("wd.cycle", 64'(wd), 8);
    cyc(); #1 chk("wd.pulse", 64'(o_timeout), 0);
    chk("wd.idle", 64'(o_staller), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
